// File: rtl/imuldiv_div_front_end_pkg.sv
// Shared definitions for the divider front end: op codes, FSM states,
// the 65-bit divider request layout and small result helpers.
package imuldiv_div_front_end_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned RESP_W = 64;
  localparam int unsigned REQ_W  = 65;

  // Request layout: [64] fn, [63:32] a, [31:0] b
  localparam int unsigned REQ_FN_BIT = 64;
  localparam int unsigned REQ_A_MSB  = 63;
  localparam int unsigned REQ_A_LSB  = 32;
  localparam int unsigned REQ_B_MSB  = 31;
  localparam int unsigned REQ_B_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } fe_state_e;

  function automatic logic op_is_signed(input logic [1:0] code);
    return (code == OP_DIV) || (code == OP_REM);
  endfunction

  function automatic logic op_sel_rem(input logic [1:0] code);
    return (code == OP_REM) || (code == OP_REMU);
  endfunction

  // Divide-by-zero result: remainder is the dividend, quotient is all ones
  // regardless of signedness.
  function automatic logic [DATA_W-1:0] div0_result(input logic [DATA_W-1:0] a,
                                                    input logic              sel_rem);
    return sel_rem ? a : 32'hffff_ffff;
  endfunction

  function automatic logic [DATA_W-1:0] select_half(input logic [RESP_W-1:0] resp,
                                                    input logic              sel_rem);
    return sel_rem ? resp[63:32] : resp[31:0];
  endfunction

endpackage

// File: rtl/imuldiv_div_front_end_if.sv
// Handshake bundle between pipeline, front end, divider and result consumer.
// The front end connects through the slave modport; the environment through master.
interface imuldiv_div_front_end_if;
  import imuldiv_div_front_end_pkg::*;

  logic              op_val;
  logic              op_rdy;
  logic [1:0]        op_code;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  logic              divreq_msg_fn;
  logic [DATA_W-1:0] divreq_msg_a;
  logic [DATA_W-1:0] divreq_msg_b;
  logic              divreq_val;
  logic              divreq_rdy;

  logic [RESP_W-1:0] divresp_msg_result;
  logic              divresp_val;
  logic              divresp_rdy;

  logic [DATA_W-1:0] result_msg;
  logic              result_val;
  logic              result_rdy;

  modport slave (
    input  op_val, op_code, op_a, op_b,
    output op_rdy,
    output divreq_msg_fn, divreq_msg_a, divreq_msg_b, divreq_val,
    input  divreq_rdy,
    input  divresp_msg_result, divresp_val,
    output divresp_rdy,
    output result_msg, result_val,
    input  result_rdy
  );

  modport master (
    output op_val, op_code, op_a, op_b,
    input  op_rdy,
    input  divreq_msg_fn, divreq_msg_a, divreq_msg_b, divreq_val,
    output divreq_rdy,
    output divresp_msg_result, divresp_val,
    input  divresp_rdy,
    input  result_msg, result_val,
    output result_rdy
  );

endinterface

// File: rtl/imuldiv_div_front_end_req_to_bits.sv
// Divider request packer (DivReqMsgToBits): fn/a/b into the 65-bit request word.
// Exact inverse of the divider's request unpacker.
module imuldiv_div_front_end_req_to_bits
  import imuldiv_div_front_end_pkg::*;
(
  input  logic              fn,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [REQ_W-1:0]  bits
);

  assign bits[REQ_FN_BIT]          = fn;
  assign bits[REQ_A_MSB:REQ_A_LSB] = a;
  assign bits[REQ_B_MSB:REQ_B_LSB] = b;

endmodule

// File: rtl/imuldiv_div_front_end.sv
// Requester-side controller for the iterative divider: accepts one op, issues
// the divider request, captures the selected response half and returns it.
module imuldiv_div_front_end
  import imuldiv_div_front_end_pkg::*;
#(
  parameter bit BYPASS_DIV0 = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  imuldiv_div_front_end_if.slave   bus
);

  fe_state_e         state_q,   state_d;
  logic              fn_q,      fn_d;
  logic              sel_rem_q, sel_rem_d;
  logic [DATA_W-1:0] a_q,       a_d;
  logic [DATA_W-1:0] b_q,       b_d;
  logic [DATA_W-1:0] result_q,  result_d;

  logic              op_rdy_s;
  logic              divreq_val_s;
  logic              divresp_rdy_s;
  logic              result_val_s;
  logic              op_fire_s;
  logic              req_fire_s;
  logic              resp_fire_s;
  logic              res_fire_s;
  logic [REQ_W-1:0]  req_bits_s;

  // Handshake strobes decode straight from the state register; held low while reset is asserted.
  always_comb begin
    op_rdy_s      = reset && (state_q == ST_IDLE);
    divreq_val_s  = reset && (state_q == ST_REQ);
    divresp_rdy_s = reset && (state_q == ST_WAIT);
    result_val_s  = reset && (state_q == ST_DONE);
    op_fire_s     = bus.op_val      && op_rdy_s;
    req_fire_s    = divreq_val_s    && bus.divreq_rdy;
    resp_fire_s   = bus.divresp_val && divresp_rdy_s;
    res_fire_s    = result_val_s    && bus.result_rdy;
  end

  // Next-state and datapath capture for the single outstanding operation.
  always_comb begin
    state_d   = state_q;
    fn_d      = fn_q;
    sel_rem_d = sel_rem_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    case (state_q)
      ST_IDLE: begin
        if (op_fire_s) begin
          fn_d      = op_is_signed(bus.op_code);
          sel_rem_d = op_sel_rem(bus.op_code);
          a_d       = bus.op_a;
          b_d       = bus.op_b;
          if (BYPASS_DIV0 && (bus.op_b == 32'd0)) begin
            result_d = div0_result(bus.op_a, op_sel_rem(bus.op_code));
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_REQ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (req_fire_s) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (resp_fire_s) begin
          result_d = select_half(bus.divresp_msg_result, sel_rem_q);
          state_d  = ST_DONE;
        end else begin
          state_d  = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (res_fire_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and operand/result registers; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      fn_q      <= 1'b0;
      sel_rem_q <= 1'b0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      fn_q      <= fn_d;
      sel_rem_q <= sel_rem_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
    end
  end

  imuldiv_div_front_end_req_to_bits u_req_to_bits (
    .fn   (fn_q),
    .a    (a_q),
    .b    (b_q),
    .bits (req_bits_s)
  );

  assign bus.op_rdy        = op_rdy_s;
  assign bus.divreq_val    = divreq_val_s;
  assign bus.divreq_msg_fn = req_bits_s[REQ_FN_BIT];
  assign bus.divreq_msg_a  = req_bits_s[REQ_A_MSB:REQ_A_LSB];
  assign bus.divreq_msg_b  = req_bits_s[REQ_B_MSB:REQ_B_LSB];
  assign bus.divresp_rdy   = divresp_rdy_s;
  assign bus.result_val    = result_val_s;
  assign bus.result_msg    = result_q;

endmodule

// File: tb/tb_imuldiv_div_front_end.sv
// Directed-vector bench for imuldiv_div_front_end with a behavioural divider
// and a result sink, plus a short randomised stream against a reference model.
module tb_imuldiv_div_front_end;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  bit   rnd_mode;
  bit   div_hold;
  int   div_lat;

  imuldiv_div_front_end_if bus ();

  imuldiv_div_front_end #(.BYPASS_DIV0(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] div_model(input logic fn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hffff_ffff};
    if (fn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] ref_result(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    if (b == 32'd0) return code[1] ? a : 32'hffff_ffff;
    r = div_model(~code[0], a, b);
    return code[1] ? r[63:32] : r[31:0];
  endfunction

  // Behavioural divider: fixed or random latency, optional request backpressure.
  initial begin
    bit busy, req_fire, resp_fire, rst_seen;
    int cnt;
    logic [63:0] pend;
    busy = 1'b0; cnt = 0; pend = 64'd0;
    bus.divreq_rdy = 1'b0; bus.divresp_val = 1'b0; bus.divresp_msg_result = 64'd0;
    forever begin
      @(negedge clk);
      req_fire  = bus.divreq_val && bus.divreq_rdy;
      resp_fire = bus.divresp_val && bus.divresp_rdy;
      rst_seen  = !reset;
      if (req_fire) pend = div_model(bus.divreq_msg_fn, bus.divreq_msg_a, bus.divreq_msg_b);
      @(posedge clk); #1;
      if (rst_seen) begin
        busy = 1'b0;
        bus.divresp_val = 1'b0;
      end else begin
        if (resp_fire) bus.divresp_val = 1'b0;
        if (req_fire) begin
          busy = 1'b1;
          cnt  = rnd_mode ? int'($urandom_range(0, 3)) : div_lat;
        end
        if (busy) begin
          if (cnt == 0) begin
            busy = 1'b0;
            bus.divresp_val = 1'b1;
            bus.divresp_msg_result = pend;
          end else begin
            cnt--;
          end
        end
      end
      bus.divreq_rdy = !busy && !bus.divresp_val && !div_hold;
    end
  end

  task automatic send_op(input string tag, input logic [1:0] code, input logic [31:0] a, input logic [31:0] b);
    bit done = 1'b0;
    bus.op_val = 1'b1; bus.op_code = code; bus.op_a = a; bus.op_b = b;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.op_rdy) done = 1'b1;
      @(posedge clk); #1;
    end
    bus.op_val = 1'b0; bus.op_code = 2'b00; bus.op_a = 32'd0; bus.op_b = 32'd0;
    check_val({tag, " accept"}, 32'(done), 32'd1);
  endtask

  // Waits for the result to fire; lat counts cycles after op fire (-1 = don't check).
  task automatic wait_res(input string tag, input logic [31:0] exp_res, input int exp_lat);
    bit done = 1'b0;
    bit saw_req = 1'b0;
    int lat = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (bus.divreq_val) saw_req = 1'b1;
      if (bus.result_val && bus.result_rdy) begin
        done = 1'b1;
        check_val(tag, bus.result_msg, exp_res);
        if (exp_lat >= 0) check_val({tag, " latency"}, 32'(lat), 32'(exp_lat));
      end
      @(posedge clk); #1;
      if (rnd_mode) bus.result_rdy = ($urandom_range(0, 3) != 0);
    end
    check_val({tag, " done"}, 32'(done), 32'd1);
    if (exp_lat == 1) check_val({tag, " no divreq"}, 32'(saw_req), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] code, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    send_op(tag, code, a, b);
    wait_res(tag, exp_res, exp_lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    n_checks = 0; n_errors = 0;
    rnd_mode = 1'b0; div_hold = 1'b0; div_lat = 0;
    reset = 1'b0;
    bus.op_val = 1'b0; bus.op_code = 2'b00; bus.op_a = 32'd0; bus.op_b = 32'd0;
    bus.result_rdy = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst op_rdy",      32'(bus.op_rdy), 32'd0);
    check_val("rst divreq_val",  32'(bus.divreq_val), 32'd0);
    check_val("rst divresp_rdy", 32'(bus.divresp_rdy), 32'd0);
    check_val("rst result_val",  32'(bus.result_val), 32'd0);
    check_val("rst result_msg",  bus.result_msg, 32'd0);
    check_val("rst fn",          32'(bus.divreq_msg_fn), 32'd0);
    check_val("rst msg_a",       bus.divreq_msg_a, 32'd0);
    check_val("rst msg_b",       bus.divreq_msg_b, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_val("idle op_rdy", 32'(bus.op_rdy), 32'd1);
    @(posedge clk); #1;

    // First op: check request fields while in REQ.
    send_op("div1", 2'b00, 32'h0000_0222, 32'h0000_002a);
    @(negedge clk);
    check_val("div1 divreq_val", 32'(bus.divreq_val), 32'd1);
    check_val("div1 fn",         32'(bus.divreq_msg_fn), 32'd1);
    check_val("div1 msg_a",      bus.divreq_msg_a, 32'h0000_0222);
    check_val("div1 msg_b",      bus.divreq_msg_b, 32'h0000_002a);
    check_val("div1 op_rdy",     32'(bus.op_rdy), 32'd0);
    @(posedge clk); #1;
    wait_res("div1", 32'h0000_000d, 2);

    run_op("rem",   2'b10, 32'h0a01_b044, 32'hffff_b14a, 32'h0000_3372, 3);
    run_op("remu",  2'b11, 32'hf5fe_4fbc, 32'h0000_4eb6, 32'h0000_06f0, 3);
    run_op("divu0", 2'b01, 32'h0000_0005, 32'h0000_0000, 32'hffff_ffff, 1);
    run_op("rem0",  2'b10, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1);
    run_op("div0s", 2'b00, 32'hffff_fff9, 32'h0000_0000, 32'hffff_ffff, 1);
    run_op("divneg", 2'b00, 32'hffff_fff9, 32'h0000_0002, 32'hffff_fffd, 3);
    run_op("remneg", 2'b10, 32'hffff_fff9, 32'h0000_0002, 32'hffff_ffff, 3);
    run_op("ovf",   2'b00, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 3);

    // Backpressure on the divider request, then on the result.
    div_hold = 1'b1;
    send_op("bp", 2'b01, 32'd1000, 32'd7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("bp divreq_val", 32'(bus.divreq_val), 32'd1);
      check_val("bp msg_a",      bus.divreq_msg_a, 32'd1000);
      check_val("bp msg_b",      bus.divreq_msg_b, 32'd7);
      check_val("bp fn",         32'(bus.divreq_msg_fn), 32'd0);
      check_val("bp op_rdy",     32'(bus.op_rdy), 32'd0);
      @(posedge clk); #1;
    end
    div_hold = 1'b0;
    bus.result_rdy = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.result_val) found = 1'b1;
      @(posedge clk); #1;
    end
    check_val("bp result seen", 32'(found), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("bp result_val", 32'(bus.result_val), 32'd1);
      check_val("bp result_msg", bus.result_msg, 32'h0000_008e);
      check_val("bp hold op_rdy", 32'(bus.op_rdy), 32'd0);
      @(posedge clk); #1;
    end
    bus.result_rdy = 1'b1;
    @(negedge clk);
    check_val("bp fire", 32'(bus.result_val), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("bp after op_rdy", 32'(bus.op_rdy), 32'd1);
    check_val("bp after result_val", 32'(bus.result_val), 32'd0);
    @(posedge clk); #1;

    // Reset pulse while waiting on the divider.
    div_lat = 3;
    send_op("rstw", 2'b00, 32'd100, 32'd7);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.divresp_rdy) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check_val("rstw in wait", 32'(found), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_val("rstw op_rdy",      32'(bus.op_rdy), 32'd1);
    check_val("rstw result_val",  32'(bus.result_val), 32'd0);
    check_val("rstw divresp_rdy", 32'(bus.divresp_rdy), 32'd0);
    check_val("rstw divreq_val",  32'(bus.divreq_val), 32'd0);
    check_val("rstw result_msg",  bus.result_msg, 32'd0);
    check_val("rstw msg_a",       bus.divreq_msg_a, 32'd0);
    @(posedge clk); #1;
    div_lat = 0;
    run_op("post rst", 2'b00, 32'd1, 32'd1, 32'd1, 3);

    // Randomised stream with random divider latency and result backpressure.
    rnd_mode = 1'b1;
    for (int n = 0; n < 48; n++) begin
      logic [1:0]  code;
      logic [31:0] a, b;
      code = 2'($urandom_range(0, 3));
      a    = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      else if ($urandom_range(0, 1) == 1) b = $urandom;
      else b = 32'($urandom_range(1, 40));
      run_op($sformatf("rnd%0d", n), code, a, b, ref_result(code, a, b), -1);
    end
    rnd_mode = 1'b0;
    bus.result_rdy = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
